// File: rtl/tx_sched.sv
// Round-robin TX scheduler: preamble/SFD, client octet mux and inter-packet gap onto one MAC port.
// eth_octet/eth_strobe lag the state by one cycle; the client is stalled only by withholding gnt.
module tx_sched #(
    parameter int N       = 3,
    parameter int IFG     = 12,
    parameter int MAX_LEN = 1530
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] cl_data,
    input  logic [N-1:0]   cl_last,
    output logic [N-1:0]   gnt,
    output logic [7:0]     eth_octet,
    output logic           eth_strobe,
    output logic           packet_start,
    output logic           busy,
    output logic           overrun
);

    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int LW = 11;
    localparam int GW = $clog2(IFG + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  win;
    logic [W-1:0]  arb;
    logic [W-1:0]  idx;
    logic          found;
    logic [2:0]    pre_cnt;
    logic [LW-1:0] len_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    win_dat;
    logic          win_last;
    logic          load_win;
    logic          src_vld;
    logic [7:0]    src_oct;
    logic          ovr_nxt;

    // The winner register doubles as the round-robin pointer.
    always_comb begin
        arb   = win;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(win) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                arb   = idx;
            end
        end
    end

    always_comb begin
        win_dat  = '0;
        win_last = 1'b0;
        gnt      = '0;
        for (int i = 0; i < N; i++) begin
            if (win == W'(i)) begin
                win_dat  = cl_data[8*i +: 8];
                win_last = cl_last[i];
            end
            gnt[i] = (state == DATA) && (win == W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        src_vld   = 1'b0;
        src_oct   = '0;
        ovr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    load_win  = 1'b1;
                    state_nxt = PRE;
                end
            end
            PRE: begin
                src_vld = 1'b1;
                src_oct = (pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
                if (pre_cnt == 3'd7) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                src_vld = 1'b1;
                src_oct = win_dat;
                // A clean last on the final allowed cycle is not an overrun.
                if (win_last) begin
                    state_nxt = GAP;
                end else if (len_cnt == LW'(MAX_LEN - 1)) begin
                    state_nxt = GAP;
                    ovr_nxt   = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(IFG - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            win          <= W'(N - 1);
            pre_cnt      <= '0;
            len_cnt      <= '0;
            gap_cnt      <= '0;
            eth_octet    <= '0;
            eth_strobe   <= 1'b0;
            packet_start <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_win) begin
                win <= arb;
            end
            pre_cnt      <= (state == PRE)  ? pre_cnt + 3'd1     : '0;
            len_cnt      <= (state == DATA) ? len_cnt + LW'(1)   : '0;
            gap_cnt      <= (state == GAP)  ? gap_cnt + GW'(1)   : '0;
            eth_octet    <= src_oct;
            eth_strobe   <= src_vld;
            packet_start <= (state == PRE) && (pre_cnt == 3'd0);
            overrun      <= ovr_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched; inputs change and outputs are sampled on the falling edge.
module tb_tx_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] cl_data;
    logic [2:0]  cl_last;
    logic [2:0]  gnt;
    logic [7:0]  eth_octet;
    logic        eth_strobe;
    logic        packet_start;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    tx_sched #(.N(3), .IFG(12), .MAX_LEN(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .cl_data      (cl_data),
        .cl_last      (cl_last),
        .gnt          (gnt),
        .eth_octet    (eth_octet),
        .eth_strobe   (eth_strobe),
        .packet_start (packet_start),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        req     = '0;
        cl_data = '0;
        cl_last = '0;
        step();
        step();
        check("rst_gnt", gnt, 0);
        check("rst_octet", eth_octet, 0);
        check("rst_strobe", eth_strobe, 0);
        check("rst_pstart", packet_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
    endtask

    // Caller has req driven at the falling edge of the arbitration cycle t.
    // Octets are d0, d0+11h, ...; with ovr the client never raises last.
    task automatic pkt(input int c, input int n, input logic [7:0] d0, input bit ovr);
        logic [7:0] d;
        logic [2:0] g;
        g = 3'(1 << c);
        step();
        check("idle_out_strobe", eth_strobe, 0);
        check("busy_pre", busy, 1);
        check("gnt_pre0", gnt, 0);
        for (int p = 0; p < 8; p++) begin
            step();
            check("pre_strobe", eth_strobe, 1);
            check("pre_octet", eth_octet, (p == 7) ? 8'hD5 : 8'h55);
            check("packet_start", packet_start, (p == 0) ? 1 : 0);
            check("gnt_pre", gnt, (p == 7) ? g : 3'b000);
        end
        d = d0;
        cl_data = '0;
        cl_data[8*c +: 8] = d;
        cl_last = (!ovr && n == 1) ? g : 3'b000;
        req = req & ~g;
        for (int k = 1; k < n; k++) begin
            step();
            check("gnt_data", gnt, g);
            check("data_octet", eth_octet, d);
            check("data_strobe", eth_strobe, 1);
            check("data_overrun", overrun, 0);
            d = d + 8'h11;
            cl_data[8*c +: 8] = d;
            cl_last = (!ovr && k == n - 1) ? g : 3'b000;
        end
        step();
        check("gnt_fall", gnt, 0);
        check("final_octet", eth_octet, d);
        check("final_strobe", eth_strobe, 1);
        check("final_overrun", overrun, ovr ? 1 : 0);
        cl_data = '0;
        cl_last = '0;
        step();
        check("gap_strobe", eth_strobe, 0);
        check("gap_octet", eth_octet, 0);
        check("gap_busy", busy, 1);
        check("gap_overrun", overrun, 0);
    endtask

    // From the second GAP cycle to the IDLE cycle: 11 more cycles.
    task automatic gap_to_idle();
        for (int i = 0; i < 11; i++) begin
            step();
            check("ifg_strobe", eth_strobe, 0);
            check("ifg_gnt", gnt, 0);
            check("ifg_busy", busy, (i != 10) ? 1 : 0);
        end
    endtask

    initial begin
        apply_reset();

        // Single 4-octet packet from client 1.
        req = 3'b010;
        pkt(1, 4, 8'hAA, 1'b0);
        gap_to_idle();

        // All clients requesting: rotation 0,1,2,0,1,2 with one-octet packets.
        apply_reset();
        req = 3'b111;
        for (int r = 0; r < 6; r++) begin
            pkt(r % 3, 1, 8'h40 + 8'(r), 1'b0);
            req = (r < 5) ? 3'b111 : 3'b000;
            gap_to_idle();
        end

        // Request raised during GAP waits for IDLE.
        req = 3'b001;
        pkt(0, 2, 8'h31, 1'b0);
        req = 3'b100;
        gap_to_idle();
        pkt(2, 1, 8'h77, 1'b0);
        req = 3'b000;
        gap_to_idle();

        // Client never asserts last: MAX_LEN forces termination.
        req = 3'b010;
        pkt(1, 20, 8'h10, 1'b1);
        req = 3'b000;
        gap_to_idle();

        // Last on the first data cycle.
        req = 3'b100;
        pkt(2, 1, 8'hE7, 1'b0);
        req = 3'b000;
        gap_to_idle();

        // Reset during the third data octet.
        req = 3'b001;
        for (int i = 0; i < 9; i++) step();
        check("rst_gnt_pre", gnt, 3'b001);
        req = 3'b000;
        cl_data = 24'h000011;
        step();
        cl_data = 24'h000022;
        step();
        cl_data = 24'h000033;
        rst = 1'b1;
        step();
        check("midrst_strobe", eth_strobe, 0);
        check("midrst_gnt", gnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_octet", eth_octet, 0);
        rst = 1'b0;
        cl_data = '0;
        req = 3'b111;
        pkt(0, 1, 8'h5A, 1'b0);
        req = 3'b000;
        gap_to_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
